// File: rtl/alu_iter.sv
// alu_iter: multi-cycle per-lane ALU with a start/busy/done handshake.
// ADD, SUB, MUL and compare complete in one EXEC cycle. DIV runs an
// iterative restoring divider that produces one quotient bit per cycle.
// A predicate gate can skip an op. A skipped op still pulses done, but the
// result registers keep their old values.
// Optional feature (macro ALU_ITER_REM_EN): adds the alu_rem output, which
// carries the remainder of the last executed DIV.
module alu_iter #(
  parameter int DATA_WIDTH = 8,
  parameter int PRED_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic [1:0]            decoded_alu_arithmetic_mux,
  input  logic                  decoded_alu_output_mux,
  input  logic                  decoded_always_execute,
  input  logic                  decoded_predicate_on,
  input  logic [PRED_WIDTH-1:0] predicate,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  div_by_zero
`ifdef ALU_ITER_REM_EN
  ,
  output logic [DATA_WIDTH-1:0] alu_rem
`endif
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q;

  // Operands and decoded fields captured when start is accepted.
  logic [1:0]            op_q;
  logic                  cmp_q;
  logic                  exec_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;

  // Divider working registers.
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  fin_q;

  // Registered outputs.
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] alu_out_q;
  logic                  dbz_q;
`ifdef ALU_ITER_REM_EN
  logic [DATA_WIDTH-1:0] alu_rem_q;
`endif

  // Decode of the live inputs, used only at start acceptance.
  logic exec_cond_s;
  logic is_div_s;
  logic rt_zero_s;
  // Decode of the latched op.
  logic op_is_div_s;
  logic [DATA_WIDTH-1:0] op_result_s;
  // Next values for one restoring-divider step.
  logic [DATA_WIDTH:0]   shift_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic [DATA_WIDTH-1:0] rem_d;
  logic [DATA_WIDTH-1:0] quo_d;

  assign exec_cond_s = decoded_always_execute | ~decoded_predicate_on |
                       (predicate != {PRED_WIDTH{1'b0}});
  assign is_div_s    = ~decoded_alu_output_mux & (decoded_alu_arithmetic_mux == 2'b11);
  assign rt_zero_s   = (rt == {DATA_WIDTH{1'b0}});
  assign op_is_div_s = ~cmp_q & (op_q == 2'b11);

  // Single-cycle result of the latched op. A DIV that reaches this path can
  // only be a divide by zero, so it yields all ones.
  always_comb begin
    op_result_s = {DATA_WIDTH{1'b0}};
    if (cmp_q) begin
      op_result_s = {{(DATA_WIDTH-1){1'b0}}, (a_q < b_q)};
    end else begin
      case (op_q)
        2'b00:   op_result_s = a_q + b_q;
        2'b01:   op_result_s = a_q - b_q;
        2'b10:   op_result_s = a_q * b_q;
        2'b11:   op_result_s = {DATA_WIDTH{1'b1}};
        default: op_result_s = {DATA_WIDTH{1'b0}};
      endcase
    end
  end

  // One restoring step: shift in the next dividend bit, then subtract the divisor if it fits.
  always_comb begin
    shift_s = {rem_q, quo_q[DATA_WIDTH-1]};
    diff_s  = shift_s - {1'b0, b_q};
    if (!diff_s[DATA_WIDTH]) begin
      rem_d = diff_s[DATA_WIDTH-1:0];
      quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shift_s[DATA_WIDTH-1:0];
      quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM plus result registers. When enable is low, all state is frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      cmp_q     <= 1'b0;
      exec_q    <= 1'b0;
      a_q       <= {DATA_WIDTH{1'b0}};
      b_q       <= {DATA_WIDTH{1'b0}};
      rem_q     <= {DATA_WIDTH{1'b0}};
      quo_q     <= {DATA_WIDTH{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      fin_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      alu_out_q <= {DATA_WIDTH{1'b0}};
      dbz_q     <= 1'b0;
`ifdef ALU_ITER_REM_EN
      alu_rem_q <= {DATA_WIDTH{1'b0}};
`endif
    end else if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q   <= decoded_alu_arithmetic_mux;
            cmp_q  <= decoded_alu_output_mux;
            exec_q <= exec_cond_s;
            a_q    <= rs;
            b_q    <= rt;
            busy_q <= 1'b1;
            if (is_div_s && exec_cond_s && !rt_zero_s) begin
              state_q <= S_DIV_RUN;
              rem_q   <= {DATA_WIDTH{1'b0}};
              quo_q   <= rs;
              cnt_q   <= CNT_LOAD;
              fin_q   <= 1'b0;
            end else begin
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          if (exec_q) begin
            alu_out_q <= op_result_s;
            dbz_q     <= op_is_div_s;
`ifdef ALU_ITER_REM_EN
            if (op_is_div_s) begin
              alu_rem_q <= a_q;
            end
`endif
          end
        end
        S_DIV_RUN: begin
          if (fin_q) begin
            // After all quotient bits are formed, commit the result.
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            alu_out_q <= quo_q;
            dbz_q     <= 1'b0;
            fin_q     <= 1'b0;
`ifdef ALU_ITER_REM_EN
            alu_rem_q <= rem_q;
`endif
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == {CNT_W{1'b0}}) begin
              fin_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign alu_out     = alu_out_q;
  assign div_by_zero = dbz_q;
`ifdef ALU_ITER_REM_EN
  assign alu_rem     = alu_rem_q;
`endif

endmodule

// File: tb/tb_alu_iter.sv
// Testbench for alu_iter. It uses directed steps taken from the test plan,
// then randomized ops. Each result is checked against an arithmetic
// reference model.
module tb_alu_iter;
  localparam int DW  = 8;
  localparam int PW  = 4;
  localparam int MOD = 1 << DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          start;
  logic [1:0]    arith;
  logic          outmux;
  logic          always_ex;
  logic          pred_on;
  logic [PW-1:0] predicate;
  logic [DW-1:0] rs;
  logic [DW-1:0] rt;
  logic          busy;
  logic          done;
  logic [DW-1:0] alu_out;
  logic          div_by_zero;
`ifdef ALU_ITER_REM_EN
  logic [DW-1:0] alu_rem;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int exp_out  = 0;
  int exp_dbz  = 0;
  int exp_rem  = 0;

  alu_iter #(.DATA_WIDTH(DW), .PRED_WIDTH(PW)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .start(start),
    .decoded_alu_arithmetic_mux(arith),
    .decoded_alu_output_mux(outmux),
    .decoded_always_execute(always_ex),
    .decoded_predicate_on(pred_on),
    .predicate(predicate),
    .rs(rs),
    .rt(rt),
    .busy(busy),
    .done(done),
    .alu_out(alu_out),
    .div_by_zero(div_by_zero)
`ifdef ALU_ITER_REM_EN
    ,
    .alu_rem(alu_rem)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int op, input bit cmp, input bit ae, input bit pon,
                         input int pred, input int a, input int b);
    arith     = op[1:0];
    outmux    = cmp;
    always_ex = ae;
    pred_on   = pon;
    predicate = pred[PW-1:0];
    rs        = a[DW-1:0];
    rt        = b[DW-1:0];
  endtask

  // Pulse start for one edge. Call this #1 after a rising edge while the DUT is idle.
  task automatic issue();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // lat counts rising edges, starting with the edge that accepted start.
  task automatic wait_done(inout int lat);
    while (done !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
  endtask

  // Reference model: update the expected outputs and return the expected latency.
  function automatic int model(input int op, input bit cmp, input bit ae, input bit pon,
                               input int pred, input int a, input int b);
    bit ex;
    int lat;
    ex  = ae || !pon || (pred % (1 << PW)) != 0;
    lat = 2;
    if (ex) begin
      if (cmp) begin
        exp_out = (a < b) ? 1 : 0;
        exp_dbz = 0;
      end else begin
        case (op)
          0: begin exp_out = (a + b) % MOD;       exp_dbz = 0; end
          1: begin exp_out = (a - b + MOD) % MOD; exp_dbz = 0; end
          2: begin exp_out = (a * b) % MOD;       exp_dbz = 0; end
          default: begin
            if (b == 0) begin
              exp_out = MOD - 1; exp_dbz = 1; exp_rem = a;
            end else begin
              exp_out = a / b;   exp_dbz = 0; exp_rem = a % b;
              lat = DW + 2;
            end
          end
        endcase
      end
    end
    return lat;
  endfunction

  task automatic do_op(input string tag, input int op, input bit cmp, input bit ae,
                       input bit pon, input int pred, input int a, input int b);
    int exp_lat;
    int lat;
    exp_lat = model(op, cmp, ae, pon, pred, a, b);
    set_ops(op, cmp, ae, pon, pred, a, b);
    issue();
    chk({tag, "_busy1"}, int'(busy), 1);
    lat = 1;
    wait_done(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy_done"}, int'(busy), 1);
    chk({tag, "_out"}, int'(alu_out), exp_out);
    chk({tag, "_dbz"}, int'(div_by_zero), exp_dbz);
`ifdef ALU_ITER_REM_EN
    chk({tag, "_rem"}, int'(alu_rem), exp_rem);
`endif
    step();
    chk({tag, "_done_off"}, int'(done), 0);
    chk({tag, "_busy_off"}, int'(busy), 0);
  endtask

  initial begin
    int lat;
    int dones;
    reset  = 1'b1;
    enable = 1'b1;
    start  = 1'b0;
    set_ops(0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out", int'(alu_out), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    step();
    step();
    reset = 1'b0;
    step();

    do_op("add_wrap", 0, 1'b0, 1'b0, 1'b0, 0, 200, 100);
    chk("add_wrap_val", int'(alu_out), 44);
    do_op("div_200_7", 3, 1'b0, 1'b0, 1'b0, 0, 200, 7);
    chk("div_200_7_val", int'(alu_out), 28);
    do_op("div_zero", 3, 1'b0, 1'b0, 1'b0, 0, 5, 0);
    chk("div_zero_val", int'(alu_out), 255);
    do_op("cmp_3_9", 0, 1'b1, 1'b0, 1'b0, 0, 3, 9);
    chk("cmp_3_9_val", int'(alu_out), 1);
    do_op("mul_skip", 2, 1'b0, 1'b0, 1'b1, 0, 10, 10);
    chk("mul_skip_val", int'(alu_out), 1);
    do_op("mul_ovf", 2, 1'b0, 1'b0, 1'b0, 0, 20, 20);
    do_op("sub_wrap", 1, 1'b0, 1'b0, 1'b0, 0, 3, 5);

    // When enable is low in DONE, the done pulse must be held.
    void'(model(0, 1'b0, 1'b0, 1'b0, 0, 1, 2));
    set_ops(0, 1'b0, 1'b0, 1'b0, 0, 1, 2);
    issue();
    lat = 1;
    wait_done(lat);
    chk("hold_lat", lat, 2);
    enable = 1'b0;
    step();
    step();
    chk("hold_done", int'(done), 1);
    chk("hold_out", int'(alu_out), 3);
    enable = 1'b1;
    step();
    chk("hold_release", int'(done), 0);

    // DIV 100/3 with enable low for 3 cycles. A start issued while busy must be ignored.
    void'(model(3, 1'b0, 1'b0, 1'b0, 0, 100, 3));
    set_ops(3, 1'b0, 1'b0, 1'b0, 0, 100, 3);
    issue();
    lat = 1;
    for (int i = 0; i < 3; i++) begin step(); lat++; end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); lat++; end
    enable = 1'b1;
    set_ops(0, 1'b0, 1'b0, 1'b0, 0, 7, 1);
    start = 1'b1;
    step();
    lat++;
    start = 1'b0;
    wait_done(lat);
    chk("stall_lat", lat, 13);
    chk("stall_out", int'(alu_out), 33);
    chk("stall_dbz", int'(div_by_zero), 0);
`ifdef ALU_ITER_REM_EN
    chk("stall_rem", int'(alu_rem), 1);
`endif
    step();
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) dones++;
      step();
    end
    chk("ignored_start_no_done", dones, 0);

    // Randomized ops checked against the model.
    for (int k = 0; k < 24; k++) begin
      int op;
      int a;
      int b;
      int pred;
      bit cmp;
      bit ae;
      bit pon;
      op   = int'($urandom_range(0, 3));
      cmp  = ($urandom_range(0, 4) == 0);
      ae   = ($urandom_range(0, 3) == 0);
      pon  = ($urandom_range(0, 1) == 1);
      pred = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 15));
      a    = int'($urandom_range(0, 255));
      b    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255));
      do_op("rand", op, cmp, ae, pon, pred, a, b);
    end

    // Assert reset asynchronously during a DIV. This must abort the op with no done.
    set_ops(3, 1'b0, 1'b0, 1'b0, 0, 250, 3);
    issue();
    for (int i = 0; i < 4; i++) step();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_out", int'(alu_out), 0);
    chk("arst_dbz", int'(div_by_zero), 0);
`ifdef ALU_ITER_REM_EN
    chk("arst_rem", int'(alu_rem), 0);
`endif
    #2;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done === 1'b1) dones++;
    end
    chk("arst_no_done", dones, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
